// File: rtl/pwconv_pkg.sv
// Shared types and helpers for the pointwise convolution layer.
// PWCONV_RELU_EN selects ReLU clamping; otherwise signed saturation.
package pwconv_pkg;

    localparam int ACC_MAX = 128;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        HOLD
    } state_t;

    function automatic int acc_width(input int bits, input int ch_in);
        return 2 * bits + 2 + $clog2(ch_in);
    endfunction

    // Arithmetic shift (floor) then clamp to the output range; the caller
    // sign-extends the accumulator to ACC_MAX and truncates the result to bits.
    function automatic logic signed [ACC_MAX-1:0] requant(
        input logic signed [ACC_MAX-1:0] acc,
        input int                        shift,
        input int                        bits
    );
        logic signed [ACC_MAX-1:0] one;
        logic signed [ACC_MAX-1:0] r;
        logic signed [ACC_MAX-1:0] hi;
        logic signed [ACC_MAX-1:0] lo;
        one = {{(ACC_MAX-1){1'b0}}, 1'b1};
        r   = acc >>> shift;
`ifdef PWCONV_RELU_EN
        hi = (one <<< bits) - one;
        lo = '0;
`else
        hi = (one <<< (bits - 1)) - one;
        lo = -(one <<< (bits - 1));
`endif
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/pwconv_group_mac.sv
// PAR_OUT parallel dot products of one pixel vector against a weight group,
// each plus its bias; purely combinational.
module pwconv_group_mac
    import pwconv_pkg::*;
#(
    parameter int BITS    = 16,
    parameter int CH_IN   = 8,
    parameter int PAR_OUT = 4,
    parameter int ACC_W   = 37
) (
    input  logic [CH_IN*BITS-1:0]         x,
    input  logic [PAR_OUT*CH_IN*BITS-1:0] w,
    input  logic [PAR_OUT*2*BITS-1:0]     b,
    output logic [PAR_OUT*ACC_W-1:0]      acc
);

    for (genvar p = 0; p < PAR_OUT; p++) begin : g_ch
        logic signed [ACC_W-1:0] sum;

        // Activations are unsigned: a zero MSB makes them non-negative signed operands.
        always_comb begin
            sum = ACC_W'($signed(b[p*2*BITS +: 2*BITS]));
            for (int c = 0; c < CH_IN; c++) begin
                sum = sum + ACC_W'($signed({1'b0, x[c*BITS +: BITS]}))
                          * ACC_W'($signed(w[(p*CH_IN+c)*BITS +: BITS]));
            end
        end

        assign acc[p*ACC_W +: ACC_W] = sum;
    end

endmodule

// File: rtl/pointwise_conv_layer.sv
// 1x1 convolution layer: output channels computed PAR_OUT at a time over G cycles.
// Clamp mode set by PWCONV_RELU_EN (defined: ReLU, undefined: signed saturation).
//
// state | meaning
// IDLE  | waiting for a pixel, in_ready high
// MAC   | computing group g, writing its data_out slices each cycle
// HOLD  | result presented with out_valid until the consumer takes it
module pointwise_conv_layer
    import pwconv_pkg::*;
#(
    parameter int BITS    = 16,
    parameter int CH_IN   = 8,
    parameter int CH_OUT  = 16,
    parameter int PAR_OUT = 4,
    parameter int SHIFT   = 12
) (
    input  logic                         clk_in,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CH_IN*BITS-1:0]        data_in,
    input  logic [CH_OUT*CH_IN*BITS-1:0] weights,
    input  logic [CH_OUT*2*BITS-1:0]     bias,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CH_OUT*BITS-1:0]       data_out,
    output logic                         busy
);

    localparam int G     = CH_OUT / PAR_OUT;
    localparam int ACC_W = acc_width(BITS, CH_IN);
    localparam int GW    = (G > 1) ? $clog2(G) : 1;
    localparam int WG    = PAR_OUT * CH_IN * BITS;
    localparam int BG    = PAR_OUT * 2 * BITS;
    localparam logic [GW-1:0] G_LAST = GW'(G - 1);

    if (CH_OUT % PAR_OUT != 0) begin : g_bad_par
        $error("CH_OUT must be a multiple of PAR_OUT");
    end
    if (ACC_W > ACC_MAX) begin : g_bad_acc
        $error("accumulator wider than requantiser supports");
    end

    state_t                   state_q;
    state_t                   state_d;
    logic [GW-1:0]            g_q;
    logic [CH_IN*BITS-1:0]    x_q;
    logic [CH_OUT*BITS-1:0]   dout_q;
    logic [WG-1:0]            w_grp;
    logic [BG-1:0]            b_grp;
    logic [PAR_OUT*ACC_W-1:0] acc_grp;
    logic                     accept;
    logic                     last_grp;

    assign accept   = in_valid && in_ready;
    assign last_grp = (g_q == G_LAST);
    assign w_grp    = weights[int'(g_q)*WG +: WG];
    assign b_grp    = bias[int'(g_q)*BG +: BG];
    assign data_out = dout_q;

    pwconv_group_mac #(
        .BITS    (BITS),
        .CH_IN   (CH_IN),
        .PAR_OUT (PAR_OUT),
        .ACC_W   (ACC_W)
    ) u_mac (
        .x   (x_q),
        .w   (w_grp),
        .b   (b_grp),
        .acc (acc_grp)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                if (last_grp) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            g_q    <= '0;
            x_q    <= '0;
            dout_q <= '0;
        end else begin
            if (accept) begin
                x_q <= data_in;
                g_q <= '0;
            end
            if (state_q == MAC) begin
                g_q <= last_grp ? '0 : g_q + 1'b1;
                for (int p = 0; p < PAR_OUT; p++) begin
                    dout_q[(int'(g_q)*PAR_OUT + p)*BITS +: BITS] <=
                        BITS'(requant(ACC_MAX'($signed(acc_grp[p*ACC_W +: ACC_W])), SHIFT, BITS));
                end
            end
        end
    end

endmodule
